maxpool2x2: RTL and testbench

//  Streaming 2x2, stride-2 max-pooling stage directly downstream of the ReLU/requantise stage.

---
 rtl/maxpool2x2.sv | 117 +++++++++++
 tb/tb_maxpool2x2.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2.sv
// maxpool2x2 -- streaming 2x2, stride-2 max-pooling stage.
//
// Accepts one signed activation per ivalid in raster order and emits one
// pooled maximum per 2x2 window. Horizontal pair maxima from even rows are
// parked in a half-width line buffer and combined with the matching pair
// on the following odd row.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous frame restart (col/row -> 0)
//   ivalid     in   din valid this cycle
//   din        in   signed activation, DW bits
//   ovalid     out  one-cycle pulse per pooled result
//   dout       out  signed pooled maximum (held while ovalid=0)
//   frame_done out  one-cycle pulse after the last pixel of a frame
module maxpool2x2 #(
  parameter int DW    = 8,
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 ivalid,
  input  logic signed [DW-1:0] din,
  output logic                 ovalid,
  output logic signed [DW-1:0] dout,
  output logic                 frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LD = IMG_W / 2;
  localparam int AW = (LD > 1) ? $clog2(LD) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam bit W_ODD = (IMG_W % 2) == 1;

  logic [CW-1:0]        col_q, col_d, col_cur;
  logic [RW-1:0]        row_q, row_d, row_cur;
  logic signed [DW-1:0] h_q, h_d;
  logic signed [DW-1:0] dout_q, dout_d;
  logic                 ovalid_q, ovalid_d;
  logic                 fdone_q, fdone_d;
  logic signed [DW-1:0] hmax, pool, lb_rd;
  logic [AW-1:0]        lb_addr;
  logic                 lb_we;

  // Not reset: every entry is written on an even row before the odd row reads it.
  logic signed [DW-1:0] lbuf [LD];

  always_comb begin
    // clr makes the current pixel (if any) position (0,0) of a fresh frame.
    col_cur  = clr ? '0 : col_q;
    row_cur  = clr ? '0 : row_q;
    lb_addr  = AW'(col_cur >> 1);
    lb_rd    = lbuf[lb_addr];
    hmax     = (din > h_q) ? din : h_q;
    pool     = (hmax > lb_rd) ? hmax : lb_rd;

    col_d    = col_cur;
    row_d    = row_cur;
    h_d      = h_q;
    dout_d   = dout_q;
    ovalid_d = 1'b0;
    fdone_d  = 1'b0;
    lb_we    = 1'b0;

    if (ivalid) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
      end
      fdone_d = (col_cur == COL_LAST) && (row_cur == ROW_LAST);

      if (!col_cur[0]) begin
        // A trailing odd column has no partner and is dropped.
        if (!(W_ODD && (col_cur == COL_LAST))) h_d = din;
      end else if (!row_cur[0]) begin
        lb_we = 1'b1;
      end else begin
        dout_d   = pool;
        ovalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      h_q      <= '0;
      dout_q   <= '0;
      ovalid_q <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      h_q      <= h_d;
      dout_q   <= dout_d;
      ovalid_q <= ovalid_d;
      fdone_q  <= fdone_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) lbuf[lb_addr] <= hmax;
  end

  assign dout       = dout_q;
  assign ovalid     = ovalid_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_maxpool2x2.sv
// tb_maxpool2x2 -- bench for maxpool2x2 using a 4x4 instance (A) and a 5x3
// instance (B). Expected results come from a stored copy of the frame: each
// 2x2 window maximum is recomputed from the pixels when its bottom-right
// pixel arrives, and directed frames are also compared with fixed lists.
module tb_maxpool2x2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, clr, iv_a, iv_b;
  logic signed [7:0] din;
  logic              ov_a, ov_b, fd_a, fd_b;
  logic signed [7:0] do_a, do_b;

  int tests = 0;
  int fails = 0;

  int W, H, r, c;
  bit sel_b;
  int frame [0:7][0:7];
  int last_dout [0:1];
  int got [$];
  int exp_q [$];

  maxpool2x2 #(.DW(8), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ivalid(iv_a), .din(din),
    .ovalid(ov_a), .dout(do_a), .frame_done(fd_a)
  );

  maxpool2x2 #(.DW(8), .IMG_W(5), .IMG_H(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ivalid(iv_b), .din(din),
    .ovalid(ov_b), .dout(do_b), .frame_done(fd_b)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int smax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check_cycle(input bit pix, input int pr, input int pc);
    int ov, dv, fd, e_ov, e_fd, e_d;
    int s;
    s    = sel_b ? 1 : 0;
    ov   = sel_b ? int'(ov_b) : int'(ov_a);
    fd   = sel_b ? int'(fd_b) : int'(fd_a);
    dv   = sel_b ? int'(do_b) : int'(do_a);
    e_ov = (pix && (pr % 2 == 1) && (pc % 2 == 1)) ? 1 : 0;
    e_fd = (pix && (pr == H - 1) && (pc == W - 1)) ? 1 : 0;
    if (e_ov == 1) begin
      e_d = smax(smax(frame[pr-1][pc-1], frame[pr-1][pc]),
                 smax(frame[pr][pc-1],   frame[pr][pc]));
      last_dout[s] = e_d;
    end else begin
      e_d = last_dout[s];
    end
    chk("ovalid", ov, e_ov);
    chk("frame_done", fd, e_fd);
    chk("dout", dv, e_d);
    if (ov == 1) got.push_back(dv);
  endtask

  task automatic pix(input int v, input bit do_clr);
    int pr, pc;
    @(negedge clk);
    if (do_clr) begin
      r   = 0;
      c   = 0;
      clr = 1'b1;
    end
    din  = 8'(v);
    iv_a = !sel_b;
    iv_b = sel_b;
    pr   = r;
    pc   = c;
    frame[pr][pc] = v;
    @(posedge clk);
    #1;
    iv_a = 1'b0;
    iv_b = 1'b0;
    clr  = 1'b0;
    check_cycle(1'b1, pr, pc);
    c++;
    if (c == W) begin
      c = 0;
      r++;
      if (r == H) r = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iv_a = 1'b0;
      iv_b = 1'b0;
      @(posedge clk);
      #1;
      check_cycle(1'b0, 0, 0);
    end
  endtask

  task automatic send_seq(input int first, input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      pix(first + i, 1'b0);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
  endtask

  task automatic expect_got(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({tag, "_val"}, got[i], exp_q[i]);
    got.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst_dout_a", int'(do_a), 0);
    chk("rst_ovalid_a", int'(ov_a), 0);
    chk("rst_fdone_a", int'(fd_a), 0);
    chk("rst_dout_b", int'(do_b), 0);
    chk("rst_ovalid_b", int'(ov_b), 0);
    chk("rst_fdone_b", int'(fd_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    r = 0;
    c = 0;
    last_dout[0] = 0;
    last_dout[1] = 0;
  endtask

  task automatic select(input bit b);
    sel_b = b;
    W = b ? 5 : 4;
    H = b ? 3 : 4;
    r = 0;
    c = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    clr   = 1'b0;
    iv_a  = 1'b0;
    iv_b  = 1'b0;
    din   = '0;
    select(1'b0);
    do_reset();
    idle(2);

    // Contiguous 0..15 frame.
    send_seq(0, 16, 0);
    exp_q = '{5, 7, 13, 15};
    expect_got("t1");
    idle(2);

    // Signed comparison: first window holds only negatives.
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       pix(-128, 1'b0);
        1:       pix(-1, 1'b0);
        4:       pix(-5, 1'b0);
        5:       pix(-2, 1'b0);
        default: pix(0, 1'b0);
      endcase
    end
    exp_q = '{-1, 0, 0, 0};
    expect_got("t2");

    // Same frame as the first, with random idle gaps.
    send_seq(0, 16, 5);
    exp_q = '{5, 7, 13, 15};
    expect_got("t3");

    // Reset partway through a frame, then a clean frame.
    send_seq(0, 6, 0);
    do_reset();
    got.delete();
    send_seq(0, 16, 0);
    exp_q = '{5, 7, 13, 15};
    expect_got("t5");

    // clr on the fourth pixel restarts the frame with that pixel at (0,0).
    send_seq(0, 3, 0);
    pix(9, 1'b1);
    send_seq(1, 15, 0);
    exp_q = '{9, 7, 13, 15};
    expect_got("t6");
    idle(1);

    // Odd dimensions on the 5x3 instance.
    select(1'b1);
    send_seq(0, 15, 0);
    exp_q = '{6, 8};
    expect_got("t4");
    idle(1);

    // Random-valued frames with random gaps on both instances.
    for (int f = 0; f < 6; f++) begin
      select(f % 2 == 1);
      for (int i = 0; i < W * H; i++) begin
        pix(int'($urandom_range(0, 255)) - 128, 1'b0);
        idle($urandom_range(0, 3));
      end
      chk("rand_count", got.size(), (W / 2) * (H / 2));
      got.delete();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
